// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths and the writeback request type.
package rf_pkg;
  localparam int XLEN = 32;
  localparam int AWIDTH = 5;
  localparam int NREGS = 32;
  localparam int LQ_DEPTH = 2;
  typedef struct packed {
    logic [AWIDTH-1:0] wa;
    logic [XLEN-1:0]   wd;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO holding long-op writeback results.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  wb_req_t       din,
  output wb_req_t       dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  wb_req_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole writer of the register file, merging ALU and long-op results
// and tracking registers still awaiting a long-op write.
module regfile_wb_arbiter
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              alu_we,
  input  logic [AWIDTH-1:0] alu_wa,
  input  logic [XLEN-1:0]   alu_wd,
  input  logic              lop_issue,
  input  logic [AWIDTH-1:0] lop_rd,
  input  logic              lop_valid,
  output logic              lop_ready,
  input  logic [AWIDTH-1:0] lop_wa,
  input  logic [XLEN-1:0]   lop_wd,
  input  logic [AWIDTH-1:0] rs1,
  input  logic [AWIDTH-1:0] rs2,
  input  logic [AWIDTH-1:0] rd,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_rd,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd
);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  wb_req_t head;
  logic [CW-1:0] count;
  logic full, empty, alu_go, fifo_go, push, issue;
  logic [NREGS-1:0] pending, pending_nxt;
  // Gating by rst_n keeps every output quiet while reset is held.
  assign alu_go = rst_n & !stall & alu_we & (|alu_wa);
  assign fifo_go = rst_n & !stall & !alu_go & !empty;
  assign lop_ready = rst_n & (count < CW'(LQ_DEPTH));
  assign push = lop_valid & lop_ready & !full & (|lop_wa);
  assign issue = !stall & lop_issue & (|lop_rd);
  wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (fifo_go),
    .din   ({lop_wa, lop_wd}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    rf_we = alu_go | fifo_go;
    rf_wa = alu_go ? alu_wa : fifo_go ? head.wa : '0;
    rf_wd = alu_go ? alu_wd : fifo_go ? head.wd : '0;
  end
  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (fifo_go) pending_nxt[head.wa] = 1'b0;
    if (issue) pending_nxt[lop_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else pending <= pending_nxt;
  assign busy_rs1 = pending[rs1];
  assign busy_rs2 = pending[rs2];
  assign busy_rd = pending[rd];
endmodule
